// File: rtl/stopwatch_display_driver.sv
// MM:SS driver for a 4-digit common-anode multiplexed 7-segment display, with a
// sequential binary-to-BCD converter and adjust-mode blinking. Optional macro:
// LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is zero.
module stopwatch_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] mincounter,
  input  logic [5:0] seccounter,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CAPT     = 3'd1;
  localparam logic [2:0] CONV_MIN = 3'd2;
  localparam logic [2:0] CONV_SEC = 3'd3;
  localparam logic [2:0] UPDATE   = 3'd4;

  logic [RW-1:0] refresh_cnt;
  logic          refresh_tick;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [2:0]    state;
  logic [5:0]    min_work, sec_work;
  logic [3:0]    min_tens, sec_tens;
  logic [3:0]    dig_mt, dig_mo, dig_st, dig_so;
  logic [1:0]    slot, next_slot;
  logic [3:0]    slot_digit;
  logic          blank;
  logic [7:0]    seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign refresh_tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst)               refresh_cnt <= '0;
    else if (refresh_tick) refresh_cnt <= '0;
    else                   refresh_cnt <= refresh_cnt + RW'(1);
  end

  // Held at zero outside adjust mode so entering adjust always starts visible.
  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Repeated-subtraction converter; digits are published together in UPDATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      min_work <= '0;
      sec_work <= '0;
      min_tens <= '0;
      sec_tens <= '0;
      dig_mt   <= '0;
      dig_mo   <= '0;
      dig_st   <= '0;
      dig_so   <= '0;
    end else begin
      case (state)
        IDLE: if (refresh_tick) state <= CAPT;
        CAPT: begin
          min_work <= mincounter;
          sec_work <= seccounter;
          min_tens <= '0;
          sec_tens <= '0;
          state    <= CONV_MIN;
        end
        CONV_MIN: begin
          if (min_work >= 6'd10) begin
            min_work <= min_work - 6'd10;
            min_tens <= min_tens + 4'd1;
          end else begin
            state <= CONV_SEC;
          end
        end
        CONV_SEC: begin
          if (sec_work >= 6'd10) begin
            sec_work <= sec_work - 6'd10;
            sec_tens <= sec_tens + 4'd1;
          end else begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          dig_mt <= min_tens;
          dig_mo <= min_work[3:0];
          dig_st <= sec_tens;
          dig_so <= sec_work[3:0];
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_slot  = slot + 2'd1;
    slot_digit = dig_so;
    case (next_slot)
      2'd3:    slot_digit = dig_mt;
      2'd2:    slot_digit = dig_mo;
      2'd1:    slot_digit = dig_st;
      default: slot_digit = dig_so;
    endcase
    // Slots 0-1 are seconds, 2-3 minutes; next_slot[1] tells them apart.
    blank = adj && blink_phase && (sel ? !next_slot[1] : next_slot[1]);
`ifdef LEADING_ZERO_BLANK_EN
    if (next_slot == 2'd3 && dig_mt == 4'd0) blank = 1'b1;
`endif
    seg_next = blank ? 8'hFF : {1'b1, seg7(slot_digit)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= 2'd3;
      an   <= 4'hF;
      seg  <= 8'hFF;
    end else if (refresh_tick) begin
      slot <= next_slot;
      an   <= ~(4'b0001 << next_slot);
      seg  <= seg_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Self-checking bench for stopwatch_display_driver: directed scenarios plus
// randomized MM:SS/adjust vectors checked against a decimal-arithmetic model.
module tb_stopwatch_display_driver;

  localparam int RDIV = 16;
  localparam int BDIV = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] mincounter = '0;
  logic [5:0] seccounter = '0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int adj_cnt     = 0;
  int exp_slot    = 3;
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  stopwatch_display_driver #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst(rst), .mincounter(mincounter), .seccounter(seccounter),
    .adj(adj), .sel(sel), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Cycles since reset release and consecutive adjust-mode cycles.
  always @(posedge clk) begin
    if (rst) begin
      cyc     = 0;
      adj_cnt = 0;
    end else begin
      cyc++;
      if (adj) adj_cnt++;
      else     adj_cnt = 0;
    end
  end

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected seg for a slot load, given the displayed time and blink history.
  function automatic logic [7:0] exp_seg(input int slot, input int m, input int s,
                                         input logic a, input logic sl, input int acnt);
    int digit;
    int phase;
    digit = (slot == 3) ? m / 10 : (slot == 2) ? m % 10 : (slot == 1) ? s / 10 : s % 10;
    phase = (a && acnt > 0) ? ((acnt - 1) / BDIV) % 2 : 0;
    if (a && phase == 1 && (sl ? slot < 2 : slot >= 2)) return 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && m / 10 == 0) return 8'hFF;
`endif
    return seg_code(digit);
  endfunction

  // Advance to just after the next slot-load edge.
  task automatic next_load();
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 4 * RDIV) begin
        $display("FAIL next_load: no slot load within %0d cycles", guard);
        miscompares++;
        $fatal(1, "bench alignment lost");
      end
    end while (cyc == 0 || cyc % RDIV != 0);
    exp_slot = (exp_slot + 1) % 4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_slot = 3;
  endtask

  task automatic skip_loads(input int n);
    for (int i = 0; i < n; i++) next_load();
  endtask

  task automatic test_reset();
    mincounter = 6'd0; seccounter = 6'd0; adj = 1'b0; sel = 1'b0;
    do_reset();
    vectors++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      $display("FAIL reset: an=%b seg=%h, required an=1111 seg=ff", an, seg);
      miscompares++;
    end
    for (int i = 1; i < RDIV; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (an !== 4'hF || seg !== 8'hFF) begin
        $display("FAIL pre_tick cycle %0d: an=%b seg=%h, required an=1111 seg=ff", i, an, seg);
        miscompares++;
      end
    end
    next_load();
    vectors++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      $display("FAIL first_tick: an=%b seg=%h, required an=1110 seg=c0", an, seg);
      miscompares++;
    end
  endtask

  task automatic test_scan();
    mincounter = 6'd12; seccounter = 6'd34;
    skip_loads(3);
    for (int i = 0; i < 4; i++) begin
      next_load();
      vectors++;
      if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 12, 34, 1'b0, 1'b0, 0)) begin
        $display("FAIL scan_12_34 slot%0d: an=%b seg=%h, required an=%b seg=%h", exp_slot,
                 an, seg, an_tab[exp_slot], exp_seg(exp_slot, 12, 34, 1'b0, 1'b0, 0));
        miscompares++;
      end
    end
  endtask

  task automatic test_mid_conversion();
    mincounter = 6'd59; seccounter = 6'd59; adj = 1'b0;
    skip_loads(3);
    for (int i = 0; i < 4; i++) begin
      next_load();
      vectors++;
      if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 59, 59, 1'b0, 1'b0, 0)) begin
        $display("FAIL steady_59_59 slot%0d: an=%b seg=%h, required an=%b seg=%h", exp_slot,
                 an, seg, an_tab[exp_slot], exp_seg(exp_slot, 59, 59, 1'b0, 1'b0, 0));
        miscompares++;
      end
    end
    // The tick just taken started a conversion; change inputs after the snapshot.
    repeat (2) @(posedge clk);
    #1;
    mincounter = 6'd0; seccounter = 6'd0;
    next_load();
    vectors++;
    if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 59, 59, 1'b0, 1'b0, 0)) begin
      $display("FAIL snapshot_kept slot%0d: an=%b seg=%h, required an=%b seg=%h", exp_slot,
               an, seg, an_tab[exp_slot], exp_seg(exp_slot, 59, 59, 1'b0, 1'b0, 0));
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      next_load();
      vectors++;
      if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 0, 0, 1'b0, 1'b0, 0)) begin
        $display("FAIL after_00_00 slot%0d: an=%b seg=%h, required an=%b seg=%h", exp_slot,
                 an, seg, an_tab[exp_slot], exp_seg(exp_slot, 0, 0, 1'b0, 1'b0, 0));
        miscompares++;
      end
    end
  endtask

  task automatic test_blink();
    mincounter = 6'd5; seccounter = 6'd7; adj = 1'b0; sel = 1'b1;
    skip_loads(3);
    adj = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 24) sel = 1'b0;
      next_load();
      vectors++;
      if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 5, 7, adj, sel, adj_cnt)) begin
        $display("FAIL blink load %0d slot%0d sel=%0b: an=%b seg=%h, required an=%b seg=%h", i,
                 exp_slot, sel, an, seg, an_tab[exp_slot], exp_seg(exp_slot, 5, 7, adj, sel, adj_cnt));
        miscompares++;
      end
    end
    adj = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_load();
      vectors++;
      if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 5, 7, 1'b0, sel, 0)) begin
        $display("FAIL blink_off slot%0d: an=%b seg=%h, required an=%b seg=%h", exp_slot,
                 an, seg, an_tab[exp_slot], exp_seg(exp_slot, 5, 7, 1'b0, sel, 0));
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    mincounter = 6'd59; seccounter = 6'd59; adj = 1'b0;
    skip_loads(4);
    // Seven edges after the tick the converter is working on the seconds.
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    mincounter = 6'd12; seccounter = 6'd34;
    @(posedge clk);
    #1;
    vectors++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      $display("FAIL reset_in_conv: an=%b seg=%h, required an=1111 seg=ff", an, seg);
      miscompares++;
    end
    rst = 1'b0;
    exp_slot = 3;
    next_load();
    vectors++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      $display("FAIL digits_cleared: an=%b seg=%h, required an=1110 seg=c0", an, seg);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      next_load();
      vectors++;
      if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, 12, 34, 1'b0, 1'b0, 0)) begin
        $display("FAIL fresh_conv slot%0d: an=%b seg=%h, required an=%b seg=%h", exp_slot,
                 an, seg, an_tab[exp_slot], exp_seg(exp_slot, 12, 34, 1'b0, 1'b0, 0));
        miscompares++;
      end
    end
  endtask

  task automatic test_leading_zero();
    int mins [2] = '{5, 15};
    adj = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mincounter = 6'(mins[k]); seccounter = 6'd7;
      skip_loads(3);
      for (int i = 0; i < 4; i++) begin
        next_load();
        vectors++;
        if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, mins[k], 7, 1'b0, 1'b0, 0)) begin
          $display("FAIL leading_zero m=%0d slot%0d: an=%b seg=%h, required an=%b seg=%h", mins[k],
                   exp_slot, an, seg, an_tab[exp_slot], exp_seg(exp_slot, mins[k], 7, 1'b0, 1'b0, 0));
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_random();
    int m, s;
    for (int v = 0; v < 24; v++) begin
      m = (v < 2) ? 63 - v : $urandom_range(0, 63);
      s = (v < 2) ? 63 - v : $urandom_range(0, 63);
      mincounter = 6'(m); seccounter = 6'(s);
      adj = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      skip_loads(3);
      for (int i = 0; i < 4; i++) begin
        next_load();
        vectors++;
        if (an !== an_tab[exp_slot] || seg !== exp_seg(exp_slot, m, s, adj, sel, adj_cnt)) begin
          $display("FAIL random %0d:%0d adj=%0b sel=%0b slot%0d: an=%b seg=%h, required an=%b seg=%h",
                   m, s, adj, sel, exp_slot, an, seg, an_tab[exp_slot],
                   exp_seg(exp_slot, m, s, adj, sel, adj_cnt));
          miscompares++;
        end
      end
    end
    adj = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_conversion();
    test_blink();
    test_reset_mid_conversion();
    test_leading_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
